// File: rtl/axis_spi_sampler.sv
// Periodic SPI burst reader of the accelerometer X/Y/Z registers, publishing 12-bit samples plus a stretched strobe.
// Latency: 130*CLK_DIV cycles of CS_N low per round; no backpressure, the consumer must catch roundDD while it is held.
module axis_spi_sampler #(
    parameter int         CLK_DIV   = 50,
    parameter int         DONE_HOLD = 1000,
    parameter int         ROUND_GAP = 100000,
    parameter logic [7:0] CMD_READ  = 8'h0B,
    parameter logic [7:0] ADDR_XL   = 8'h0E
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start_en,
    input  logic        MISO,
    output logic        SCLK,
    output logic        MOSI,
    output logic        CS_N,
    output logic [11:0] x_reg_temp,
    output logic [11:0] y_reg_temp,
    output logic [11:0] z_reg_temp,
    output logic        roundDD,
    output logic        busy
);

    localparam int WAIT_MAX = (ROUND_GAP > DONE_HOLD) ? ROUND_GAP : DONE_HOLD;
    localparam int DIV_W    = $clog2(CLK_DIV + 1);
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        DONE,
        GAP
    } state_t;

    state_t             state, state_nx;
    logic [DIV_W-1:0]   div_cnt, div_nx;
    logic [5:0]         bit_cnt, bit_nx;
    logic [WAIT_W-1:0]  wait_cnt, wait_nx;
    logic [14:0]        tx_sr, tx_nx;
    logic [47:0]        rx_sr, rx_nx;
    logic               sclk_nx, mosi_nx, cs_n_nx, done_nx;
    logic [11:0]        x_nx, y_nx, z_nx;
    logic               last_div;

    assign last_div = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign busy     = ~CS_N;

    always_comb begin
        state_nx = state;
        div_nx   = div_cnt;
        bit_nx   = bit_cnt;
        wait_nx  = wait_cnt;
        tx_nx    = tx_sr;
        rx_nx    = rx_sr;
        sclk_nx  = SCLK;
        mosi_nx  = MOSI;
        cs_n_nx  = CS_N;
        done_nx  = roundDD;
        x_nx     = x_reg_temp;
        y_nx     = y_reg_temp;
        z_nx     = z_reg_temp;

        case (state)
            IDLE: begin
                if (start_en) begin
                    state_nx = CS_SETUP;
                    cs_n_nx  = 1'b0;
                    div_nx   = '0;
                    tx_nx    = {CMD_READ[6:0], ADDR_XL};
                    mosi_nx  = CMD_READ[7];
                    rx_nx    = '0;
                end
            end

            CS_SETUP: begin
                if (last_div) begin
                    state_nx = SHIFT;
                    div_nx   = '0;
                    bit_nx   = '0;
                end else begin
                    div_nx = div_cnt + DIV_W'(1);
                end
            end

            SHIFT: begin
                if (!last_div) begin
                    div_nx = div_cnt + DIV_W'(1);
                end else begin
                    div_nx = '0;
                    if (!SCLK) begin
                        // Rising SCLK edge: sensor data is stable here in mode 0.
                        sclk_nx = 1'b1;
                        rx_nx   = {rx_sr[46:0], MISO};
                    end else begin
                        sclk_nx = 1'b0;
                        if (bit_cnt == 6'd63) begin
                            state_nx = CS_HOLD;
                            mosi_nx  = 1'b0;
                        end else begin
                            bit_nx  = bit_cnt + 6'd1;
                            mosi_nx = tx_sr[14];
                            tx_nx   = {tx_sr[13:0], 1'b0};
                        end
                    end
                end
            end

            CS_HOLD: begin
                if (last_div) begin
                    state_nx = DONE;
                    cs_n_nx  = 1'b1;
                    done_nx  = 1'b1;
                    wait_nx  = '0;
                    // Burst byte order XL,XH,YL,YH,ZL,ZH; high-nibble sign bits are dropped.
                    x_nx     = {rx_sr[35:32], rx_sr[47:40]};
                    y_nx     = {rx_sr[19:16], rx_sr[31:24]};
                    z_nx     = {rx_sr[3:0],   rx_sr[15:8]};
                end else begin
                    div_nx = div_cnt + DIV_W'(1);
                end
            end

            DONE: begin
                if (wait_cnt == WAIT_W'(DONE_HOLD - 1)) begin
                    state_nx = GAP;
                    done_nx  = 1'b0;
                    wait_nx  = '0;
                end else begin
                    wait_nx = wait_cnt + WAIT_W'(1);
                end
            end

            GAP: begin
                if (wait_cnt == WAIT_W'(ROUND_GAP - 1)) begin
                    wait_nx = '0;
                    if (start_en) begin
                        state_nx = CS_SETUP;
                        cs_n_nx  = 1'b0;
                        div_nx   = '0;
                        tx_nx    = {CMD_READ[6:0], ADDR_XL};
                        mosi_nx  = CMD_READ[7];
                        rx_nx    = '0;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    wait_nx = wait_cnt + WAIT_W'(1);
                end
            end

            default: begin
                state_nx = IDLE;
                cs_n_nx  = 1'b1;
                sclk_nx  = 1'b0;
                mosi_nx  = 1'b0;
                done_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            wait_cnt   <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            SCLK       <= 1'b0;
            MOSI       <= 1'b0;
            CS_N       <= 1'b1;
            roundDD    <= 1'b0;
            x_reg_temp <= '0;
            y_reg_temp <= '0;
            z_reg_temp <= '0;
        end else begin
            state      <= state_nx;
            div_cnt    <= div_nx;
            bit_cnt    <= bit_nx;
            wait_cnt   <= wait_nx;
            tx_sr      <= tx_nx;
            rx_sr      <= rx_nx;
            SCLK       <= sclk_nx;
            MOSI       <= mosi_nx;
            CS_N       <= cs_n_nx;
            roundDD    <= done_nx;
            x_reg_temp <= x_nx;
            y_reg_temp <= y_nx;
            z_reg_temp <= z_nx;
        end
    end

endmodule

// File: tb/tb_axis_spi_sampler.sv
// Bench for axis_spi_sampler: behavioural SPI sensor feeding a scoreboard, monitor checks framing and samples.
module tb_axis_spi_sampler;

    localparam int CLK_DIV   = 2;
    localparam int DONE_HOLD = 4;
    localparam int ROUND_GAP = 20;
    localparam int CS_LOW    = 130 * CLK_DIV;
    localparam int PERIOD    = CS_LOW + DONE_HOLD + ROUND_GAP;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        start_en = 1'b0;
    logic        MISO = 1'b0;
    logic        SCLK, MOSI, CS_N, roundDD, busy;
    logic [11:0] x_reg_temp, y_reg_temp, z_reg_temp;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic [11:0] z;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   rounds_started = 0;
    int   rounds_done = 0;
    int   edge_cnt = 0;
    bit   in_round = 1'b0;
    bit   cont_mode = 1'b0;

    // Byte order on the wire: XL, XH, YL, YH, ZL, ZH.
    logic [47:0] dir_tab [3] = '{48'h23_01_FF_07_00_08,
                                 48'h01_F8_5A_3C_C3_E5,
                                 48'h77_A3_00_F0_FF_0F};

    always #5 CLK = ~CLK;

    axis_spi_sampler #(
        .CLK_DIV   (CLK_DIV),
        .DONE_HOLD (DONE_HOLD),
        .ROUND_GAP (ROUND_GAP),
        .CMD_READ  (8'h0B),
        .ADDR_XL   (8'h0E)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .start_en   (start_en),
        .MISO       (MISO),
        .SCLK       (SCLK),
        .MOSI       (MOSI),
        .CS_N       (CS_N),
        .x_reg_temp (x_reg_temp),
        .y_reg_temp (y_reg_temp),
        .z_reg_temp (z_reg_temp),
        .roundDD    (roundDD),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic wait_rounds(input int target, input int budget, input string name);
        int n = 0;
        while (rounds_done < target && n < budget) begin
            @(negedge CLK);
            n++;
        end
        check(name, 64'(rounds_done >= target), 64'(1));
    endtask

    task automatic wait_edge(input int target, input int budget, input string name);
        int n = 0;
        while (!(in_round && edge_cnt >= target) && n < budget) begin
            @(negedge CLK);
            n++;
        end
        check(name, 64'(in_round && edge_cnt >= target), 64'(1));
    endtask

    // Mode-0 sensor: presents each bit before the SCLK rise, advances after it.
    initial begin : sensor
        logic [63:0] stream;
        logic [47:0] bytes;
        logic [7:0]  b [6];
        logic        p_cs, p_sclk;
        exp_t        e;
        p_cs   = 1'b1;
        p_sclk = 1'b0;
        stream = '0;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                if (in_round && exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
                in_round = 1'b0;
                edge_cnt = 0;
                MISO     = 1'b0;
                p_cs     = 1'b1;
                p_sclk   = 1'b0;
            end else begin
                if (p_cs && !CS_N) begin
                    if (rounds_started < 3) bytes = dir_tab[rounds_started];
                    else                    bytes = 48'({$urandom(), $urandom()});
                    for (int i = 0; i < 6; i++) b[i] = 8'(bytes >> (8 * (5 - i)));
                    e.x = 12'((int'(b[1]) % 16) * 256 + int'(b[0]));
                    e.y = 12'((int'(b[3]) % 16) * 256 + int'(b[2]));
                    e.z = 12'((int'(b[5]) % 16) * 256 + int'(b[4]));
                    exp_q.push_back(e);
                    stream = {16'($urandom()), bytes};
                    rounds_started++;
                    in_round = 1'b1;
                    edge_cnt = 0;
                    MISO     = stream[63];
                end else if (in_round && !p_sclk && SCLK) begin
                    edge_cnt++;
                    if (edge_cnt < 64) MISO = stream[63 - edge_cnt];
                end
                if (!p_cs && CS_N) in_round = 1'b0;
                p_cs   = CS_N;
                p_sclk = SCLK;
            end
        end
    end

    initial begin : monitor
        logic        p_cs, p_sclk, p_dd, cs_rose;
        logic [11:0] px, py, pz;
        logic [63:0] mosi_w;
        int          low_len, dd_len, rises, t, last_fall;
        exp_t        e;
        p_cs = 1'b1; p_sclk = 1'b0; p_dd = 1'b0;
        px = '0; py = '0; pz = '0; mosi_w = '0;
        low_len = 0; dd_len = 0; rises = 0; t = 0; last_fall = -1;
        forever begin
            @(negedge CLK);
            t++;
            if (!RST) begin
                p_cs = 1'b1; p_sclk = 1'b0; p_dd = 1'b0;
                low_len = 0; dd_len = 0; rises = 0; mosi_w = '0; last_fall = -1;
                px = x_reg_temp; py = y_reg_temp; pz = z_reg_temp;
            end else begin
                cs_rose = !p_cs && CS_N;
                if (p_cs && !CS_N) begin
                    if (cont_mode && last_fall >= 0)
                        check("round_period", 64'(t - last_fall), 64'(PERIOD));
                    check("busy_on_cs_fall", 64'(busy), 64'(1));
                    last_fall = t; low_len = 0; rises = 0; mosi_w = '0;
                end
                if (!CS_N) begin
                    low_len++;
                    if (!p_sclk && SCLK) begin
                        rises++;
                        mosi_w = {mosi_w[62:0], MOSI};
                    end
                end
                if (cs_rose) begin
                    check("cs_low_cycles", 64'(low_len), 64'(CS_LOW));
                    check("sclk_rises", 64'(rises), 64'(64));
                    check("mosi_cmd_addr", 64'(mosi_w[63:48]), 64'(16'h0B0E));
                    check("mosi_dummy_zero", 64'(mosi_w[47:0]), 64'(0));
                    check("busy_on_cs_rise", 64'(busy), 64'(0));
                    check("roundDD_with_cs_rise", 64'(roundDD), 64'(1));
                end
                if (!p_dd && roundDD) begin
                    dd_len = 0;
                    if (exp_q.size() == 0) begin
                        check("scoreboard_nonempty", 64'(0), 64'(1));
                    end else begin
                        e = exp_q.pop_front();
                        check("x_sample", 64'(x_reg_temp), 64'(e.x));
                        check("y_sample", 64'(y_reg_temp), 64'(e.y));
                        check("z_sample", 64'(z_reg_temp), 64'(e.z));
                    end
                end
                if (roundDD) dd_len++;
                if (p_dd && !roundDD) begin
                    check("roundDD_width", 64'(dd_len), 64'(DONE_HOLD));
                    rounds_done++;
                end
                if (x_reg_temp != px || y_reg_temp != py || z_reg_temp != pz)
                    check("xyz_change_only_at_cs_rise", 64'(cs_rose), 64'(1));
                p_cs = CS_N; p_sclk = SCLK; p_dd = roundDD;
                px = x_reg_temp; py = y_reg_temp; pz = z_reg_temp;
            end
        end
    end

    initial begin : stimulus
        int activity, rs0, rd0;
        repeat (3) @(negedge CLK);
        check("rst_cs_n", 64'(CS_N), 64'(1));
        check("rst_sclk", 64'(SCLK), 64'(0));
        check("rst_mosi", 64'(MOSI), 64'(0));
        check("rst_xyz", 64'({x_reg_temp, y_reg_temp, z_reg_temp}), 64'(0));
        check("rst_roundDD", 64'(roundDD), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        #1 RST = 1'b1;

        activity = 0;
        repeat (300) begin
            @(negedge CLK);
            if (!CS_N || SCLK || MOSI || roundDD || busy ||
                x_reg_temp != 0 || y_reg_temp != 0 || z_reg_temp != 0) activity++;
        end
        check("idle_quiet_cycles", 64'(activity), 64'(0));
        check("idle_no_rounds", 64'(rounds_started), 64'(0));

        cont_mode = 1'b1;
        start_en  = 1'b1;
        wait_rounds(5, 5 * PERIOD + 400, "continuous_rounds_timeout");

        wait_edge(20, PERIOD + 100, "mid_shift_wait_timeout");
        cont_mode = 1'b0;
        start_en  = 1'b0;
        rs0 = rounds_started;
        rd0 = rounds_done;
        wait_rounds(rd0 + 1, PERIOD + 100, "drop_round_completes_timeout");
        repeat (150) @(negedge CLK);
        check("idle_after_drop", 64'(rounds_started), 64'(rs0));
        check("cs_high_after_drop", 64'(CS_N), 64'(1));
        start_en = 1'b1;
        @(negedge CLK);
        check("restart_next_clk", 64'(CS_N), 64'(0));

        wait_edge(30, PERIOD + 100, "bit30_wait_timeout");
        @(posedge CLK);
        #2 RST = 1'b0;
        #1;
        check("async_rst_cs_n", 64'(CS_N), 64'(1));
        check("async_rst_sclk", 64'(SCLK), 64'(0));
        check("async_rst_xyz", 64'({x_reg_temp, y_reg_temp, z_reg_temp}), 64'(0));
        check("async_rst_roundDD", 64'(roundDD), 64'(0));
        check("async_rst_busy", 64'(busy), 64'(0));
        repeat (3) @(negedge CLK);
        #1 RST = 1'b1;
        rd0 = rounds_done;
        wait_rounds(rd0 + 1, PERIOD + 100, "post_reset_round_timeout");
        start_en = 1'b0;
        repeat (PERIOD + 50) @(negedge CLK);
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
